// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: ALU/load write-back requests, issue port and register-file write/busy outputs
interface wb_arbiter_if #(parameter int DATA_W = 64);
  logic              alu_valid, alu_ready, alu_sp;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid, ld_ready, ld_sp;
  logic [4:0]        ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              iss_valid, iss_sp;
  logic [4:0]        iss_rd;
  logic              rf_we;
  logic [4:0]        rf_wr_reg;
  logic [DATA_W-1:0] rf_wr_data;
  logic [31:0]       busy;
  modport master (
    output alu_valid, alu_rd, alu_sp, alu_data, ld_valid, ld_rd, ld_sp, ld_data,
           iss_valid, iss_rd, iss_sp,
    input  alu_ready, ld_ready, rf_we, rf_wr_reg, rf_wr_data, busy
  );
  modport slave (
    input  alu_valid, alu_rd, alu_sp, alu_data, ld_valid, ld_rd, ld_sp, ld_data,
           iss_valid, iss_rd, iss_sp,
    output alu_ready, ld_ready, rf_we, rf_wr_reg, rf_wr_data, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back port arbiter (load priority) with pending-write busy scoreboard
// Optional ALU anti-starvation limit enabled by defining WB_ARB_STARVE_EN.
module wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  logic              force_alu, alu_gnt, ld_gnt, xfer, wr;
  logic [4:0]        w_rd;
  logic              w_sp;
  logic [DATA_W-1:0] w_data;
  logic [31:0]       set_v, clr_v;
`ifdef WB_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve;
  assign force_alu = bus.alu_valid && bus.ld_valid && starve == CW'(STARVE_MAX);
  always_ff @(posedge clk)
    if (reset || !bus.alu_valid || alu_gnt) starve <= '0;
    else if (bus.ld_valid && ld_gnt) starve <= starve + 1'b1;
`else
  assign force_alu = 1'b0;
`endif
  assign alu_gnt = !reset && bus.alu_valid && (!bus.ld_valid || force_alu);
  assign ld_gnt  = !reset && bus.ld_valid && !force_alu;
  assign bus.alu_ready = alu_gnt;
  assign bus.ld_ready  = ld_gnt;
  always_comb begin
    xfer   = alu_gnt || ld_gnt;
    w_rd   = alu_gnt ? bus.alu_rd : bus.ld_rd;
    w_sp   = alu_gnt ? bus.alu_sp : bus.ld_sp;
    w_data = alu_gnt ? bus.alu_data : bus.ld_data;
    wr     = xfer && !(w_rd == 5'd31 && !w_sp);
    clr_v  = wr ? 32'd1 << w_rd : 32'd0;
    set_v  = (bus.iss_valid && (bus.iss_rd != 5'd31 || bus.iss_sp)) ? 32'd1 << bus.iss_rd : 32'd0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      bus.rf_we      <= 1'b0;
      bus.rf_wr_reg  <= '0;
      bus.rf_wr_data <= '0;
      bus.busy       <= '0;
    end else begin
      bus.rf_we <= wr;
      if (wr) begin
        bus.rf_wr_reg  <= w_rd;
        bus.rf_wr_data <= w_data;
      end
      bus.busy <= (bus.busy & ~clr_v) | set_v;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed plus randomized check of wb_arbiter against a behavioural model
module tb_wb_arbiter;
  localparam int DW = 64, SM = 4;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  wb_arbiter_if #(.DATA_W(DW)) bus();
  wb_arbiter #(.DATA_W(DW), .STARVE_MAX(SM)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0, fails = 0;
  bit mb[32];
  bit m_we;
  bit [4:0] m_reg;
  bit [DW-1:0] m_data;
  int m_starve = 0;
  bit ag, lg;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] busy_vec();
    bit [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mb[i];
    return v;
  endfunction

  task automatic set_alu(bit v, bit [4:0] rd, bit sp, bit [DW-1:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_sp = sp; bus.alu_data = d;
  endtask
  task automatic set_ld(bit v, bit [4:0] rd, bit sp, bit [DW-1:0] d);
    bus.ld_valid = v; bus.ld_rd = rd; bus.ld_sp = sp; bus.ld_data = d;
  endtask
  task automatic set_iss(bit v, bit [4:0] rd, bit sp);
    bus.iss_valid = v; bus.iss_rd = rd; bus.iss_sp = sp;
  endtask

  // Inputs are applied just after a rising edge; grants are checked mid-cycle,
  // registered outputs just after the next rising edge.
  task automatic cyc();
    bit both;
    bit [4:0] rd;
    bit sp;
    bit [DW-1:0] d;
    #3;
    both = bus.alu_valid && bus.ld_valid;
    ag = 0; lg = 0;
    if (!reset) begin
`ifdef WB_ARB_STARVE_EN
      if (both && m_starve == SM) ag = 1;
      else
`endif
      if (bus.ld_valid) lg = 1;
      else if (bus.alu_valid) ag = 1;
    end
    check("alu_ready", bus.alu_ready, ag);
    check("ld_ready", bus.ld_ready, lg);
    @(posedge clk);
    if (reset) begin
      foreach (mb[i]) mb[i] = 0;
      m_we = 0; m_reg = 0; m_data = 0; m_starve = 0;
    end else begin
      m_we = 0;
      if (ag || lg) begin
        rd = ag ? bus.alu_rd : bus.ld_rd;
        sp = ag ? bus.alu_sp : bus.ld_sp;
        d  = ag ? bus.alu_data : bus.ld_data;
        if (!(rd == 31 && !sp)) begin
          m_we = 1; m_reg = rd; m_data = d; mb[rd] = 0;
        end
      end
      if (bus.iss_valid && (bus.iss_rd != 31 || bus.iss_sp)) mb[bus.iss_rd] = 1;
      m_starve = (both && lg) ? m_starve + 1 : 0;
    end
    #1;
    check("rf_we", bus.rf_we, m_we);
    check("rf_wr_reg", bus.rf_wr_reg, m_reg);
    check("rf_wr_data", bus.rf_wr_data, m_data);
    check("busy", bus.busy, busy_vec());
  endtask

  initial begin
    int na;
    set_alu(1, 2, 0, 64'h55); set_ld(1, 9, 0, 64'h66); set_iss(1, 1, 0);
    #1; cyc(); cyc();
    check("reset_busy", bus.busy, 0);
    check("reset_we", bus.rf_we, 0);
    reset = 0;
    set_alu(0, 0, 0, 0); set_ld(0, 0, 0, 0); set_iss(1, 5, 0);
    cyc();
    check("iss5_busy", bus.busy[5], 1);
    set_iss(0, 0, 0); set_alu(1, 5, 0, 64'hDEAD_BEEF);
    cyc();
    check("alu_we", bus.rf_we, 1);
    check("alu_reg", bus.rf_wr_reg, 5);
    check("alu_data", bus.rf_wr_data, 64'hDEAD_BEEF);
    check("alu_busy5", bus.busy[5], 0);
    set_alu(1, 3, 0, 64'h33); set_ld(1, 4, 0, 64'h44);
    cyc();
    check("coll_ld_reg", bus.rf_wr_reg, 4);
    set_ld(0, 0, 0, 0);
    cyc();
    check("coll_alu_reg", bus.rf_wr_reg, 3);
    set_alu(0, 0, 0, 0); set_ld(1, 31, 0, 64'h1234);
    cyc();
    check("xzr_we", bus.rf_we, 0);
    set_ld(0, 0, 0, 0); set_iss(1, 31, 1);
    cyc();
    set_iss(0, 0, 0); set_ld(1, 31, 1, 64'h1234);
    cyc();
    check("sp_we", bus.rf_we, 1);
    check("sp_reg", bus.rf_wr_reg, 31);
    check("sp_busy31", bus.busy[31], 0);
    set_ld(0, 0, 0, 0); set_iss(1, 7, 0);
    cyc();
    set_ld(1, 7, 0, 64'h77);
    cyc();
    check("race_reg", bus.rf_wr_reg, 7);
    check("race_busy7", bus.busy[7], 1);
    set_iss(0, 0, 0); set_alu(1, 10, 0, 64'hA); set_ld(1, 11, 0, 64'hB);
    na = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (ag) na++;
    end
`ifdef WB_ARB_STARVE_EN
    check("starve_alu_grants", na, 2);
`else
    check("starve_alu_grants", na, 0);
`endif
    set_alu(0, 0, 0, 0); set_ld(0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      set_iss(1, 5'(i), 1);
      cyc();
    end
    check("all_busy", bus.busy, 32'hFFFF_FFFF);
    set_iss(0, 0, 0); set_alu(1, 12, 0, 64'hC);
    cyc();
    reset = 1;
    cyc();
    check("rst_mid_we", bus.rf_we, 0);
    check("rst_mid_busy", bus.busy, 0);
    reset = 0;
    for (int n = 0; n < 3000; n++) begin
      if (ag || !bus.alu_valid)
        set_alu($urandom_range(0, 3) != 0, ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom),
                1'($urandom), {$urandom, $urandom});
      if (lg || !bus.ld_valid)
        set_ld($urandom_range(0, 3) != 0, ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom),
               1'($urandom), {$urandom, $urandom});
      set_iss($urandom_range(0, 1) == 1, ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom), 1'($urandom));
      reset = $urandom_range(0, 49) == 0;
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
